icetap_jtag_tap: RTL and testbench

//   IEEE 1149.1 TAP controller and instruction register feeding icetap_top_jtag.

---
 rtl/icetap_jtag_tap_if.sv | 33 +++
 rtl/icetap_jtag_tap.sv | 140 ++++++++++++++
 tb/tb_icetap_jtag_tap.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/icetap_jtag_tap_if.sv
// Purpose: bundles the JTAG pin and strobe signals of icetap_jtag_tap.
//   slave  : the TAP controller (consumes tms/tdi/icetap_tdo, drives the rest)
//   master : the JTAG host / register block side
// Signals:
//   tms, tdi, icetap_tdo                      host -> TAP
//   tdo, tdo_oe                               TAP  -> pins
//   test_logic_reset, capture_dr, shift_dr,
//   update_dr, scan_n_ir, extest_ir           TAP  -> icetap register block
interface icetap_jtag_tap_if;
  logic tms;
  logic tdi;
  logic icetap_tdo;
  logic tdo;
  logic tdo_oe;
  logic test_logic_reset;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic scan_n_ir;
  logic extest_ir;

  modport slave (
    input  tms, tdi, icetap_tdo,
    output tdo, tdo_oe, test_logic_reset, capture_dr, shift_dr, update_dr,
           scan_n_ir, extest_ir
  );

  modport master (
    output tms, tdi, icetap_tdo,
    input  tdo, tdo_oe, test_logic_reset, capture_dr, shift_dr, update_dr,
           scan_n_ir, extest_ir
  );
endinterface

// File: rtl/icetap_jtag_tap.sv
// Purpose: IEEE 1149.1 TAP controller with instruction register, IDCODE and
//   BYPASS data registers. Exports DR-phase strobes and IR decodes to the
//   icetap JTAG register block and muxes its serial output onto tdo.
// Ports:
//   tck     JTAG clock, all state changes on the rising edge
//   reset_  asynchronous active-low reset (power-on / TRST)
//   bus     icetap_jtag_tap_if.slave: tms/tdi/icetap_tdo in; tdo, tdo_oe,
//           test_logic_reset, capture_dr, shift_dr, update_dr, scan_n_ir,
//           extest_ir out
module icetap_jtag_tap #(
  parameter int                  IR_BITS      = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1001_41A3,
  parameter logic [IR_BITS-1:0]  OP_EXTEST    = 'h0,
  parameter logic [IR_BITS-1:0]  OP_SCAN_N    = 'h2,
  parameter logic [IR_BITS-1:0]  OP_IDCODE    = 'hE,
  parameter logic [IR_BITS-1:0]  OP_BYPASS    = 'hF
) (
  input  logic               tck,
  input  logic               reset_,
  icetap_jtag_tap_if.slave   bus
);

  typedef enum logic [3:0] {
    S_TLR     = 4'd0,
    S_RTI     = 4'd1,
    S_SEL_DR  = 4'd2,
    S_CAP_DR  = 4'd3,
    S_SH_DR   = 4'd4,
    S_EX1_DR  = 4'd5,
    S_PAU_DR  = 4'd6,
    S_EX2_DR  = 4'd7,
    S_UPD_DR  = 4'd8,
    S_SEL_IR  = 4'd9,
    S_CAP_IR  = 4'd10,
    S_SH_IR   = 4'd11,
    S_EX1_IR  = 4'd12,
    S_PAU_IR  = 4'd13,
    S_EX2_IR  = 4'd14,
    S_UPD_IR  = 4'd15
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IR_BITS-1:0]   r_ir;
  logic [IR_BITS-1:0]   r_ir_shift;
  logic [31:0]          r_idcode_sr;
  logic                 r_bypass_sr;

  logic                 w_sel_idcode;
  logic                 w_sel_scan_n;
  logic                 w_sel_extest;
  logic                 w_sel_bypass;

  // State register
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) r_state <= S_TLR;
    else         r_state <= w_next;
  end

  // Next-state logic (1149.1 TMS graph)
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_TLR:    w_next = bus.tms ? S_TLR    : S_RTI;
      S_RTI:    w_next = bus.tms ? S_SEL_DR : S_RTI;
      S_SEL_DR: w_next = bus.tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: w_next = bus.tms ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  w_next = bus.tms ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: w_next = bus.tms ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: w_next = bus.tms ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: w_next = bus.tms ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: w_next = bus.tms ? S_SEL_DR : S_RTI;
      S_SEL_IR: w_next = bus.tms ? S_TLR    : S_CAP_IR;
      S_CAP_IR: w_next = bus.tms ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  w_next = bus.tms ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: w_next = bus.tms ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: w_next = bus.tms ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: w_next = bus.tms ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: w_next = bus.tms ? S_SEL_DR : S_RTI;
      default:  w_next = S_TLR;
    endcase
  end

  // Instruction register: the active IR only moves on Update-IR, or is forced
  // to IDCODE on the very edge that lands in Test-Logic-Reset.
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      r_ir       <= OP_IDCODE;
      r_ir_shift <= '0;
    end else begin
      if (w_next == S_TLR)        r_ir <= OP_IDCODE;
      else if (r_state == S_UPD_IR) r_ir <= r_ir_shift;

      if (r_state == S_CAP_IR)     r_ir_shift <= IR_BITS'(2'b01);
      else if (r_state == S_SH_IR) r_ir_shift <= {bus.tdi, r_ir_shift[IR_BITS-1:1]};
    end
  end

  // IDCODE and BYPASS data registers; Pause/Exit states simply hold.
  always_ff @(posedge tck or negedge reset_) begin
    if (!reset_) begin
      r_idcode_sr <= '0;
      r_bypass_sr <= 1'b0;
    end else if (r_state == S_CAP_DR) begin
      r_idcode_sr <= IDCODE_VALUE;
      r_bypass_sr <= 1'b0;
    end else if (r_state == S_SH_DR) begin
      r_idcode_sr <= {bus.tdi, r_idcode_sr[31:1]};
      r_bypass_sr <= bus.tdi;
    end
  end

  // IR decodes; anything not explicitly listed falls back to BYPASS.
  assign w_sel_idcode = (r_ir == OP_IDCODE);
  assign w_sel_scan_n = (r_ir == OP_SCAN_N);
  assign w_sel_extest = (r_ir == OP_EXTEST);
  assign w_sel_bypass = (r_ir == OP_BYPASS) ||
                        !(w_sel_idcode || w_sel_scan_n || w_sel_extest);

  // Outputs: pure decodes of registered state, so strobes span a full tck cycle.
  always_comb begin
    bus.test_logic_reset = (r_state == S_TLR);
    bus.capture_dr       = (r_state == S_CAP_DR);
    bus.shift_dr         = (r_state == S_SH_DR);
    bus.update_dr        = (r_state == S_UPD_DR);
    bus.scan_n_ir        = w_sel_scan_n;
    bus.extest_ir        = w_sel_extest;
    bus.tdo_oe           = (r_state == S_SH_IR) || (r_state == S_SH_DR);
    bus.tdo              = 1'b0;
    if (r_state == S_SH_IR) begin
      bus.tdo = r_ir_shift[0];
    end else if (r_state == S_SH_DR) begin
      if (w_sel_idcode)                     bus.tdo = r_idcode_sr[0];
      else if (w_sel_scan_n || w_sel_extest) bus.tdo = bus.icetap_tdo;
      else if (w_sel_bypass)                 bus.tdo = r_bypass_sr;
      else                                   bus.tdo = r_bypass_sr;
    end
  end

endmodule

// File: tb/tb_icetap_jtag_tap.sv
module tb_icetap_jtag_tap;
  logic tck;
  logic reset_;
  int   n_checks;
  int   n_errors;

  icetap_jtag_tap_if jif();

  icetap_jtag_tap dut (
    .tck    (tck),
    .reset_ (reset_),
    .bus    (jif.slave)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive tms/tdi away from the rising edge, then settle just after it.
  task automatic step(input logic t, input logic d);
    @(negedge tck);
    jif.tms = t;
    jif.tdi = d;
    @(posedge tck);
    #1;
  endtask

  // From RTI: load an instruction, end back in RTI.
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  logic [31:0] idc;
  logic [3:0]  irv;
  logic [3:0]  byp_in;
  logic [3:0]  byp_out;
  logic [11:0] w_tms, w_sh, w_cap, w_upd;
  int cnt_cap, cnt_sh, cnt_upd;

  initial begin
    n_checks = 0;
    n_errors = 0;
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    jif.icetap_tdo = 1'b0;
    reset_ = 1'b0;
    idc     = 32'h1001_41A3;
    irv     = 4'h2;
    byp_in  = 4'b1101;   // tdi 1,0,1,1 (LSB first)
    byp_out = 4'b1010;   // tdo 0,1,0,1
    w_tms = 12'b0110_1010_0001;
    w_sh  = 12'b0001_0001_1100;
    w_cap = 12'b0000_0000_0010;
    w_upd = 12'b0100_0000_0000;

    // Reset state
    #12;
    chk("rst_tlr",    jif.test_logic_reset, 1);
    chk("rst_cap",    jif.capture_dr, 0);
    chk("rst_shift",  jif.shift_dr, 0);
    chk("rst_upd",    jif.update_dr, 0);
    chk("rst_tdo",    jif.tdo, 0);
    chk("rst_tdo_oe", jif.tdo_oe, 0);
    chk("rst_scan_n", jif.scan_n_ir, 0);
    chk("rst_extest", jif.extest_ir, 0);
    @(negedge tck);
    reset_ = 1'b1;

    // Test 1: one tck with tms=0 leaves TLR
    step(1'b0, 1'b0);
    chk("t1_tlr_low", jif.test_logic_reset, 0);

    // Test 3: IDCODE read from RTI
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t3_capture", jif.capture_dr, 1);
    step(1'b0, 1'b0);
    chk("t3_shift", jif.shift_dr, 1);
    chk("t3_oe", jif.tdo_oe, 1);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t3_idbit%0d", i), jif.tdo, idc[i]);
      step(i == 31, 1'b0);
    end
    chk("t3_exit_oe", jif.tdo_oe, 0);
    step(1'b1, 1'b0);
    chk("t3_update", jif.update_dr, 1);
    step(1'b0, 1'b0);

    // Test 4: load SCAN_N, watching the captured 01 pattern shift out
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t4_ir_oe", jif.tdo_oe, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_irtdo%0d", i), jif.tdo, (i == 0) ? 1 : 0);
      step(i == 3, irv[i]);
    end
    step(1'b1, 1'b0);
    chk("t4_scan_n_in_upd", jif.scan_n_ir, 0);
    step(1'b0, 1'b0);
    chk("t4_scan_n", jif.scan_n_ir, 1);
    chk("t4_extest", jif.extest_ir, 0);

    // Test 6: DR walk with pause under SCAN_N
    cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
    for (int i = 0; i < 12; i++) begin
      step(w_tms[i], 1'b0);
      jif.icetap_tdo = (i % 3) != 1;
      #1;
      cnt_cap += int'(jif.capture_dr);
      cnt_sh  += int'(jif.shift_dr);
      cnt_upd += int'(jif.update_dr);
      chk($sformatf("t6_shift%0d", i), jif.shift_dr, w_sh[i]);
      chk($sformatf("t6_cap%0d", i), jif.capture_dr, w_cap[i]);
      chk($sformatf("t6_upd%0d", i), jif.update_dr, w_upd[i]);
      chk($sformatf("t6_tdo%0d", i), jif.tdo, w_sh[i] ? ((i % 3) != 1) : 1'b0);
    end
    chk("t6_cap_cnt", cnt_cap, 1);
    chk("t6_sh_cnt",  cnt_sh,  4);
    chk("t6_upd_cnt", cnt_upd, 1);

    // Test 5: unlisted opcode behaves as BYPASS
    load_ir(4'h5);
    chk("t5_scan_n", jif.scan_n_ir, 0);
    chk("t5_extest", jif.extest_ir, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_byp%0d", i), jif.tdo, byp_out[i]);
      step(1'b0, byp_in[i]);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Test 2: EXTEST, then five tms=1 from Shift-DR back to TLR
    load_ir(4'h0);
    chk("t2_extest", jif.extest_ir, 1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    cnt_upd = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      cnt_upd += int'(jif.update_dr);
    end
    chk("t2_tlr", jif.test_logic_reset, 1);
    chk("t2_extest_off", jif.extest_ir, 0);
    chk("t2_upd_path", cnt_upd, 1);
    // IDCODE is active again: first DR bit out must be 1
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t2_idcode_bit0", jif.tdo, 1);

    // Async reset in the middle of a scan
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge tck);
    #2;
    reset_ = 1'b0;
    #1;
    chk("ar_tlr", jif.test_logic_reset, 1);
    chk("ar_shift", jif.shift_dr, 0);
    chk("ar_oe", jif.tdo_oe, 0);
    chk("ar_tdo", jif.tdo, 0);
    cnt_upd = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      cnt_upd += int'(jif.update_dr);
    end
    chk("ar_no_update", cnt_upd, 0);
    @(negedge tck);
    reset_ = 1'b1;
    step(1'b0, 1'b0);
    chk("ar_rti", jif.test_logic_reset, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
